dp_mem_bram: RTL and testbench
==============================

DP_MEM_BRAM -- requirements
Module: dp_mem_bram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address width; depth = 2**ADDR_WIDTH words (256).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, word width in bits for both ports.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1: single clock shared by both ports; all activity on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-006 SHALL have port ena, input, 1: port A enable.
REQ-007 SHALL have port wea, input, 1: port A write enable; ignored when ena=0.
REQ-008 SHALL have port addra, input, ADDR_WIDTH: port A word address.
REQ-009 SHALL have port dina, input, DATA_WIDTH: port A write data.
REQ-010 SHALL have port douta, output, DATA_WIDTH: port A read data.
REQ-011 SHALL have ports enb, web, addrb, dinb, doutb, identical in direction, width and meaning to the port A set, for port B.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits; both ports are full read/write ports with identical behaviour.
REQ-013 Write: en=1, we=1 at a clock edge SHALL store din at addr; the whole word is written, with no byte enables.
REQ-014 Read: en=1 at edge N SHALL load dout with mem[addr] and make it visible after edge N, giving 1-cycle latency.
REQ-015 Read-first: a write cycle (en=1, we=1) SHALL also load dout, with the word's contents before the write.
REQ-016 en=0 SHALL leave dout holding its last value and SHALL NOT modify memory.
REQ-017 Cross-port, same address, A writes and B reads in the same cycle: B SHALL return the old data; the new data is visible from the next read.
REQ-018 Both ports writing the same address in the same cycle: port B data SHALL be stored.
REQ-019 Different addresses SHALL be fully independent on both ports in every cycle.
REQ-020 Memory SHALL start as all-zero at power-up and time 0 in simulation.
REQ-021 Addresses SHALL be word indices with no alignment masking; every address in 0..2**ADDR_WIDTH-1 is valid, with no wrap or out-of-range case.

Reset
REQ-022 While rst_i=1 at an edge, douta and doutb SHALL be 0 after that edge.
REQ-023 While rst_i=1, all writes SHALL be suppressed on both ports.
REQ-024 Reset SHALL NOT clear memory contents; data written before reset remains readable after it.
REQ-025 Reset asserted during an access SHALL cancel that access, leaving no write and dout=0.
REQ-026 The first edge after rst_i deasserts SHALL perform normal accesses.

Configuration
REQ-027 Macro DP_MEM_BRAM_OUTREG_EN defined: each port SHALL add a second output register after the REQ-014 register, giving 2-cycle read latency.
REQ-028 Under DP_MEM_BRAM_OUTREG_EN, each second output register SHALL be cleared by rst_i and SHALL always advance, regardless of en.
REQ-029 DP_MEM_BRAM_OUTREG_EN undefined: read latency SHALL be 1 cycle as in REQ-014.

Verification (macro undefined unless stated)
REQ-030 After reset, A writes 0x0123..CDEF (128-bit) to addr 0x10; next cycle B reads 0x10 -> doutb = that value one cycle later.
REQ-031 Same cycle: A writes 0xAA..AA to addr 0x20 (which held 0x55..55) and B reads 0x20 -> doutb = 0x55..55; B reads again -> 0xAA..AA.
REQ-032 Same cycle: A writes 0x1 and B writes 0x2 to addr 0xFF -> subsequent read of 0xFF returns 0x2.
REQ-033 Write 0xDEAD to addr 0x00, then assert rst_i for 2 cycles with wea=1, dina=0xBEEF -> douta=doutb=0 during reset; after reset, read of 0x00 returns 0xDEAD.
REQ-034 Read addr 0x10, then hold ena=0 for 3 cycles while changing addra -> douta stays at the addr 0x10 data.
REQ-035 With DP_MEM_BRAM_OUTREG_EN defined, read addr 0x10 at edge N -> douta valid after edge N+1 and still 0 after edge N.

Source files
------------

// File: rtl/dp_mem_bram.sv
// dp_mem_bram: true dual-port, single-clock block RAM with read-first ports.
//
// Both ports (A and B) are full read/write ports with identical behaviour.
// A read or a write cycle loads the port's output register with the word's
// contents from before any write in that cycle. When both ports write the
// same word in the same cycle, port B's data is stored. Reset clears the
// output registers and blocks writes. It does not clear the storage array.
//
// Optional feature (macro DP_MEM_BRAM_OUTREG_EN):
//   Adds a second output register per port, so read latency is 2 cycles.
//   This register is cleared by rst_i and advances every cycle,
//   regardless of en.
//
// Parameters:
//   ADDR_WIDTH  word-address width; depth = 2**ADDR_WIDTH words
//   DATA_WIDTH  word width in bits for both ports
//
// Ports:
//   clk_i              shared clock; all activity on its rising edge
//   rst_i              synchronous active-high reset
//   ena / enb          port enable
//   wea / web          port write enable; ignored when the port enable is low
//   addra / addrb      word address
//   dina / dinb        write data
//   douta / doutb      read data (registered)

module dp_mem_bram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,

    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Storage array; power-up contents are all zero.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // First-stage read registers (the outputs when the extra stage is absent).
    logic [DATA_WIDTH-1:0] rda_q;
    logic [DATA_WIDTH-1:0] rdb_q;

    // Both ports share one process so that port B's write, issued last,
    // wins a same-address collision. Nonblocking reads see pre-write data,
    // which gives read-first behaviour within a port and across ports.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rda_q <= '0;
            rdb_q <= '0;
        end else begin
            if (ena) begin
                rda_q <= mem[addra];
                if (wea) begin
                    mem[addra] <= dina;
                end
            end
            if (enb) begin
                rdb_q <= mem[addrb];
                if (web) begin
                    mem[addrb] <= dinb;
                end
            end
        end
    end

`ifdef DP_MEM_BRAM_OUTREG_EN
    // Second output stage: free-running, independent of the port enables.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            douta <= '0;
            doutb <= '0;
        end else begin
            douta <= rda_q;
            doutb <= rdb_q;
        end
    end
`else
    assign douta = rda_q;
    assign doutb = rdb_q;
`endif

endmodule

// File: tb/tb_dp_mem_bram.sv
module tb_dp_mem_bram;

`ifdef DP_MEM_BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [127:0] V_10  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] V_55  = {16{8'h55}};
    localparam logic [127:0] V_AA  = {16{8'hAA}};
    localparam logic [127:0] V_DED = 128'hDEAD;
    localparam logic [127:0] V_BEF = 128'hBEEF;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ena, wea, enb, web;
    logic [7:0]   addra, addrb;
    logic [127:0] dina, dinb;
    logic [127:0] douta, doutb;

    dp_mem_bram dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .enb   (enb),
        .web   (web),
        .addrb (addrb),
        .dinb  (dinb),
        .doutb (doutb)
    );

    always #5 clk_i = ~clk_i;

    // Edge counter; an expectation tagged with cycle c is checked at the
    // falling edge after the c-th rising edge.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        int           port;
        logic [127:0] exp;
        string        name;
    } exp_t;

    exp_t         sbq[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] act;

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk_i) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                act = (sbq[i].port == 0) ? douta : doutb;
                n_cmp++;
                if (act !== sbq[i].exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             sbq[i].name, act, sbq[i].exp, cyc);
                end
                sbq.delete(i);
            end else if (sbq[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation overdue at cycle %0d", sbq[i].name, cyc);
                sbq.delete(i);
            end
        end
    end

    // Queue an expectation dly edges after the upcoming one becomes current.
    task automatic expect_at(input int dly, input int port, input logic [127:0] v,
                             input string nm);
        exp_t e;
        e.cyc  = cyc + dly;
        e.port = port;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // Drive one cycle of inputs (called at a falling edge) and advance.
    task automatic step(input logic ea, input logic wa, input logic [7:0] aa,
                        input logic [127:0] da,
                        input logic eb, input logic wb, input logic [7:0] ab,
                        input logic [127:0] db);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
        @(negedge clk_i);

        // Reset state.
        expect_at(1, 0, '0, "rst_douta");
        expect_at(1, 1, '0, "rst_doutb");
        step(0, 0, 8'h00, '0, 0, 0, 8'h00, '0);
        rst_i = 1'b0;

        // Untouched word reads as zero (power-up contents).
        expect_at(LAT, 0, '0, "pwrup_a_30");
        expect_at(LAT, 1, '0, "pwrup_b_ff");
        step(1, 0, 8'h30, '0, 1, 0, 8'hFF, '0);

        // A writes 0x10 (read-first returns old zero), then B reads it.
        expect_at(LAT, 0, '0, "wr10_readfirst_a");
        step(1, 1, 8'h10, V_10, 0, 0, 8'h00, '0);
        expect_at(LAT, 1, V_10, "rd10_b");
        step(0, 0, 8'h00, '0, 1, 0, 8'h10, '0);

        // Cross-port collision: A writes 0xAA.. while B reads 0x20.
        step(1, 1, 8'h20, V_55, 0, 0, 8'h00, '0);
        expect_at(LAT, 0, V_55, "wr20_readfirst_a");
        expect_at(LAT, 1, V_55, "xport_old_b");
        step(1, 1, 8'h20, V_AA, 1, 0, 8'h20, '0);
        expect_at(LAT, 1, V_AA, "xport_new_b");
        step(0, 0, 8'h00, '0, 1, 0, 8'h20, '0);

        // Both ports write 0xFF: B wins.
        expect_at(LAT, 0, '0, "dualwr_old_a");
        expect_at(LAT, 1, '0, "dualwr_old_b");
        step(1, 1, 8'hFF, 128'h1, 1, 1, 8'hFF, 128'h2);
        expect_at(LAT, 0, 128'h2, "dualwr_b_wins");
        step(1, 0, 8'hFF, '0, 0, 0, 8'h00, '0);

        // Write 0xDEAD to 0x00, then reset with writes pending.
        step(1, 1, 8'h00, V_DED, 0, 0, 8'h00, '0);
        rst_i = 1'b1;
        expect_at(1, 0, '0, "rst1_douta");
        expect_at(1, 1, '0, "rst1_doutb");
        step(1, 1, 8'h00, V_BEF, 1, 1, 8'h00, V_BEF);
        expect_at(1, 0, '0, "rst2_douta");
        expect_at(1, 1, '0, "rst2_doutb");
        step(1, 1, 8'h00, V_BEF, 1, 1, 8'h00, V_BEF);
        rst_i = 1'b0;

        // Contents survive reset and the suppressed writes did not land.
        expect_at(LAT, 0, V_DED, "post_rst_a_00");
        expect_at(LAT, 1, V_DED, "post_rst_b_00");
        step(1, 0, 8'h00, '0, 1, 0, 8'h00, '0);

        // Read 0x10 on A, then hold ena=0 with a moving address.
`ifdef DP_MEM_BRAM_OUTREG_EN
        expect_at(1, 0, V_DED, "outreg_lat2_old_a");
`endif
        expect_at(LAT, 0, V_10, "rd10_a");
        step(1, 0, 8'h10, '0, 0, 0, 8'h00, '0);
        for (int i = 0; i < 3; i++) begin
            expect_at(LAT, 0, V_10, $sformatf("hold_a_%0d", i));
            step(0, 1, 8'(8'h40 + i), V_BEF, 0, 0, 8'h00, '0);
        end

        // The held writes above must not have landed; neighbouring words
        // written in the same cycle stay independent.
        expect_at(LAT, 0, '0, "hold_nowrite_40");
        step(1, 0, 8'h40, '0, 0, 0, 8'h00, '0);
        step(1, 1, 8'h40, 128'h11, 1, 1, 8'h41, 128'h22);
        expect_at(LAT, 0, 128'h22, "indep_a_41");
        expect_at(LAT, 1, 128'h11, "indep_b_40");
        step(1, 0, 8'h41, '0, 1, 0, 8'h40, '0);

        // Drain outstanding expectations.
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, '0, 0, 0, 8'h00, '0);
        while (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked", sbq[0].name);
            void'(sbq.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
